// File: rtl/adc_conv_reader.sv
// adc_conv_reader: AD7822 conversion/readout controller with start-pulse and periodic triggering.
module adc_conv_reader #(
    parameter int DATA_W      = 8,
    parameter int WAIT_CYC    = 1,
    parameter int AUTO_PERIOD = 8
) (
    input  logic              clk_200kHz,
    input  logic              reset,
    input  logic              ADC_ready,
    input  logic              start,
    input  logic              auto_en,
    input  logic [DATA_W-1:0] DB,
    output logic              CONVST,
    output logic              CS_n,
    output logic              RD_n,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] READ = 2'd3;
    localparam int PW = $clog2(AUTO_PERIOD + 1);
    logic [1:0]        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [PW-1:0]     per_q, per_d;
    logic              convst_q, convst_d;
    logic              csrd_q, csrd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic              auto_tick, trig;
    always_comb begin
        auto_tick = auto_en & ADC_ready & (per_q == PW'(AUTO_PERIOD - 1));
        trig      = start | auto_tick;
        per_d     = (auto_en & ADC_ready & !auto_tick) ? per_q + PW'(1) : '0;
        // Losing ADC_ready aborts from any state straight back to IDLE.
        state_d   = !ADC_ready          ? IDLE :
                    state_q == IDLE     ? (trig ? CONV : IDLE) :
                    state_q == CONV     ? WAIT :
                    state_q == WAIT     ? (wcnt_q == 4'(WAIT_CYC - 1) ? READ : WAIT) :
                                          IDLE;
        wcnt_d    = state_q == WAIT ? wcnt_q + 4'd1 : 4'd0;
        convst_d  = state_d != CONV;
        csrd_d    = state_d != READ;
        valid_d   = (state_q == READ) & ADC_ready;
        data_d    = valid_d ? DB : data_q;
        busy_d    = state_d != IDLE;
        ovr_d     = ovr_q | (trig & ADC_ready & (state_q != IDLE));
    end
    always_ff @(posedge clk_200kHz or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            per_q    <= '0;
            convst_q <= 1'b1;
            csrd_q   <= 1'b1;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            per_q    <= per_d;
            convst_q <= convst_d;
            csrd_q   <= csrd_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end
    assign CONVST     = convst_q;
    assign CS_n       = csrd_q;
    assign RD_n       = csrd_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
endmodule
